// File: rtl/match_dispatcher_pkg.sv
// match_dispatcher_pkg
// Shared constants and types for the match dispatcher and its downstream
// consumer (laggy_prefix):
//   DEF_BITMASK_WIDTH - default fiber bitmask width in bits
//   DEF_WEIGHT_WIDTH  - default width of one compressed weight
//   disp_state_e      - dispatcher FSM state encoding
package match_dispatcher_pkg;

  localparam int DEF_BITMASK_WIDTH = 16;
  localparam int DEF_WEIGHT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } disp_state_e;

endpackage : match_dispatcher_pkg

// File: rtl/match_dispatcher_fast_prefix_popcount.sv
// fast_prefix_popcount
// Combinational count of the set bits of bits_i strictly below position
// pos_i. This is the compressed-storage index of the weight that belongs to
// bit pos_i of a sparse bitmask.
// Ports:
//   bits_i  [BITMASK_WIDTH-1:0]         nonzero-weight bitmask
//   pos_i   [clog2(BITMASK_WIDTH)-1:0]  bit position of interest
//   count_o [clog2(BITMASK_WIDTH)-1:0]  popcount(bits_i & ((1<<pos_i)-1))
module fast_prefix_popcount
  import match_dispatcher_pkg::*;
#(
  parameter int BITMASK_WIDTH = DEF_BITMASK_WIDTH
) (
  input  logic [BITMASK_WIDTH-1:0]         bits_i,
  input  logic [$clog2(BITMASK_WIDTH)-1:0] pos_i,
  output logic [$clog2(BITMASK_WIDTH)-1:0] count_o
);

  localparam int PW = $clog2(BITMASK_WIDTH);

  logic [BITMASK_WIDTH-1:0] below_s;
  logic [PW-1:0]            acc_s;

  // Thermometer mask of positions below pos_i, applied to the bitmask.
  always_comb begin
    below_s = {BITMASK_WIDTH{1'b0}};
    for (int i = 0; i < BITMASK_WIDTH; i++) begin
      below_s[i] = bits_i[i] & (PW'(i) < pos_i);
    end
  end

  // Population count of the masked bits. At most BITMASK_WIDTH-1 bits can be
  // set below any position, so PW bits never overflow, even for the MSB.
  always_comb begin
    acc_s = {PW{1'b0}};
    for (int i = 0; i < BITMASK_WIDTH; i++) begin
      acc_s = acc_s + {{(PW-1){1'b0}}, below_s[i]};
    end
  end

  assign count_o = acc_s;

endmodule : fast_prefix_popcount

// File: rtl/match_dispatcher.sv
// match_dispatcher
// Intersects a spike bitmask (fiber A) with a nonzero-weight bitmask
// (fiber B) and emits one match per cycle in ascending bit order, together
// with the compressed B weight for that position. Emission stalls while the
// downstream FIFO is full.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_valid/ready  fiber-pair load handshake (ready only in IDLE)
//   bitmask_a/b       fiber A spike mask, fiber B nonzero mask
//   weights_b         compressed B weights, entry k at [k*W +: W]
//   fifo_full         downstream backpressure
//   and_result        latched A & B
//   bitmask_a_out     latched A
//   matched_position  bit index of the emitted match
//   matched_weight    B weight of the emitted match
//   valid_match       one-cycle strobe per match
//   done              one-cycle pulse once the pair is exhausted
//   match_count       matches emitted for the current pair
module match_dispatcher
  import match_dispatcher_pkg::*;
#(
  parameter int BITMASK_WIDTH = DEF_BITMASK_WIDTH,
  parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [BITMASK_WIDTH-1:0]          bitmask_a,
  input  logic [BITMASK_WIDTH-1:0]          bitmask_b,
  input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] weights_b,
  input  logic                              fifo_full,
  output logic [BITMASK_WIDTH-1:0]          and_result,
  output logic [BITMASK_WIDTH-1:0]          bitmask_a_out,
  output logic [$clog2(BITMASK_WIDTH)-1:0]  matched_position,
  output logic [WEIGHT_WIDTH-1:0]           matched_weight,
  output logic                              valid_match,
  output logic                              done,
  output logic [$clog2(BITMASK_WIDTH):0]    match_count
);

  localparam int PW = $clog2(BITMASK_WIDTH);
  localparam int CW = PW + 1;
  localparam logic [BITMASK_WIDTH-1:0] ONE_M = {{(BITMASK_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]            ONE_C = {{(CW-1){1'b0}}, 1'b1};

  disp_state_e                       state_q;
  logic [BITMASK_WIDTH-1:0]          remaining_q;
  logic [BITMASK_WIDTH-1:0]          bitmask_b_q;
  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] weights_q;
  logic                              load_ready_q;
  logic [BITMASK_WIDTH-1:0]          and_result_q;
  logic [BITMASK_WIDTH-1:0]          bitmask_a_q;
  logic [PW-1:0]                     matched_position_q;
  logic [WEIGHT_WIDTH-1:0]           matched_weight_q;
  logic                              valid_match_q;
  logic                              done_q;
  logic [CW-1:0]                     match_count_q;

  logic [PW-1:0]                     lsb_pos_d;
  logic [PW-1:0]                     prefix_cnt_d;
  logic [WEIGHT_WIDTH-1:0]           weight_sel_d;

  // Lowest-set-bit priority encoder over the remaining mask; scanning from
  // the MSB down lets the lowest set bit win the final assignment.
  always_comb begin
    lsb_pos_d = {PW{1'b0}};
    for (int i = BITMASK_WIDTH - 1; i >= 0; i--) begin
      lsb_pos_d = remaining_q[i] ? PW'(i) : lsb_pos_d;
    end
  end

  fast_prefix_popcount #(
    .BITMASK_WIDTH (BITMASK_WIDTH)
  ) u_prefix (
    .bits_i  (bitmask_b_q),
    .pos_i   (lsb_pos_d),
    .count_o (prefix_cnt_d)
  );

  // Weight mux: select compressed entry prefix_cnt_d.
  always_comb begin
    weight_sel_d = {WEIGHT_WIDTH{1'b0}};
    for (int k = 0; k < BITMASK_WIDTH; k++) begin
      weight_sel_d = (prefix_cnt_d == PW'(k)) ? weights_q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                                              : weight_sel_d;
    end
  end

  // Dispatcher FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      remaining_q        <= {BITMASK_WIDTH{1'b0}};
      bitmask_b_q        <= {BITMASK_WIDTH{1'b0}};
      weights_q          <= {(BITMASK_WIDTH*WEIGHT_WIDTH){1'b0}};
      load_ready_q       <= 1'b1;
      and_result_q       <= {BITMASK_WIDTH{1'b0}};
      bitmask_a_q        <= {BITMASK_WIDTH{1'b0}};
      matched_position_q <= {PW{1'b0}};
      matched_weight_q   <= {WEIGHT_WIDTH{1'b0}};
      valid_match_q      <= 1'b0;
      done_q             <= 1'b0;
      match_count_q      <= {CW{1'b0}};
    end else begin
      // Strobes default low; they are raised only for the cycle they qualify.
      valid_match_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // load_ready_q is high throughout IDLE, so load_valid alone
          // completes the handshake here.
          if (load_valid) begin
            state_q       <= ST_SCAN;
            load_ready_q  <= 1'b0;
            bitmask_a_q   <= bitmask_a;
            bitmask_b_q   <= bitmask_b;
            weights_q     <= weights_b;
            remaining_q   <= bitmask_a & bitmask_b;
            and_result_q  <= bitmask_a & bitmask_b;
            match_count_q <= {CW{1'b0}};
          end else begin
            state_q      <= ST_IDLE;
            load_ready_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (remaining_q == {BITMASK_WIDTH{1'b0}}) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (!fifo_full) begin
            matched_position_q <= lsb_pos_d;
            matched_weight_q   <= weight_sel_d;
            valid_match_q      <= 1'b1;
            // Clear the lowest set bit.
            remaining_q        <= remaining_q & (remaining_q - ONE_M);
            match_count_q      <= match_count_q + ONE_C;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready       = load_ready_q;
  assign and_result       = and_result_q;
  assign bitmask_a_out    = bitmask_a_q;
  assign matched_position = matched_position_q;
  assign matched_weight   = matched_weight_q;
  assign valid_match      = valid_match_q;
  assign done             = done_q;
  assign match_count      = match_count_q;

endmodule : match_dispatcher

// File: tb/tb_match_dispatcher.sv
// tb_match_dispatcher
// Self-checking bench for match_dispatcher (16-bit masks, 8-bit weights).
// Expected matches come from a list built directly from A&B and the
// prefix-popcount weight rule; a per-edge schedule decides when each match
// or the done pulse must appear given the applied fifo_full pattern.
module tb_match_dispatcher;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [15:0]  bitmask_a;
  logic [15:0]  bitmask_b;
  logic [127:0] weights_b;
  logic         fifo_full;
  logic [15:0]  and_result;
  logic [15:0]  bitmask_a_out;
  logic [3:0]   matched_position;
  logic [7:0]   matched_weight;
  logic         valid_match;
  logic         done;
  logic [4:0]   match_count;

  int n_checks = 0;
  int n_pass   = 0;

  match_dispatcher #(
    .BITMASK_WIDTH (16),
    .WEIGHT_WIDTH  (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .bitmask_a        (bitmask_a),
    .bitmask_b        (bitmask_b),
    .weights_b        (weights_b),
    .fifo_full        (fifo_full),
    .and_result       (and_result),
    .bitmask_a_out    (bitmask_a_out),
    .matched_position (matched_position),
    .matched_weight   (matched_weight),
    .valid_match      (valid_match),
    .done             (done),
    .match_count      (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_weights();
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Load one pair and follow it to completion.
  // stall_s/stall_n: fifo_full forced high for SCAN edges [stall_s, stall_s+stall_n)
  // rnd_stall: additional random stalls; busy: random load_valid during SCAN.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input logic [127:0] w,
                          input int stall_s, input int stall_n, input bit rnd_stall, input bit busy);
    int          exp_pos[$];
    int          exp_w[$];
    int          n, idx, cyc, cidx;
    bit          full, fin;
    logic [15:0] ab;
    logic [15:0] lowmask;

    ab = a & b;
    for (int p = 0; p < 16; p++) begin
      if (ab[p]) begin
        lowmask = (16'h0001 << p) - 16'h0001;
        cidx = $countones(b & lowmask);
        exp_pos.push_back(p);
        exp_w.push_back(int'(w[cidx*8 +: 8]));
      end
    end
    n = exp_pos.size();

    cyc = 0;
    while (!load_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_load", {31'd0, load_ready}, 32'd1);

    bitmask_a  = a;
    bitmask_b  = b;
    weights_b  = w;
    load_valid = 1'b1;
    fifo_full  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_low_in_scan", {31'd0, load_ready}, 32'd0);
    check("and_result_load", {16'd0, and_result}, {16'd0, ab});
    check("a_out_load", {16'd0, bitmask_a_out}, {16'd0, a});
    check("count_cleared", {27'd0, match_count}, 32'd0);

    load_valid = busy ? 1'b1 : 1'b0;
    if (busy) begin
      bitmask_a = 16'($urandom);
      bitmask_b = 16'($urandom);
      weights_b = rand_weights();
    end

    idx  = 0;
    cyc  = 0;
    fin  = 1'b0;
    full = (cyc >= stall_s && cyc < stall_s + stall_n) || (rnd_stall && $urandom_range(0, 3) == 0);
    fifo_full = full;

    while (!fin && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      if (idx < n) begin
        if (!full) begin
          check("valid_on_emit", {31'd0, valid_match}, 32'd1);
          check("position", {28'd0, matched_position}, exp_pos[idx]);
          check("weight", {24'd0, matched_weight}, exp_w[idx]);
          check("count_running", {27'd0, match_count}, idx + 1);
          check("no_early_done", {31'd0, done}, 32'd0);
          idx++;
        end else begin
          check("no_emit_on_stall", {31'd0, valid_match}, 32'd0);
          check("no_done_on_stall", {31'd0, done}, 32'd0);
        end
      end else begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("no_valid_at_done", {31'd0, valid_match}, 32'd0);
        check("count_final", {27'd0, match_count}, n);
        check("and_result_hold", {16'd0, and_result}, {16'd0, ab});
        check("a_out_hold", {16'd0, bitmask_a_out}, {16'd0, a});
        fin = 1'b1;
      end
      cyc++;
      full = (cyc >= stall_s && cyc < stall_s + stall_n) || (rnd_stall && $urandom_range(0, 3) == 0);
      fifo_full = full;
      if (fin) begin
        load_valid = 1'b0;
      end else if (busy) begin
        load_valid = 1'($urandom_range(0, 1));
        bitmask_a  = 16'($urandom);
        bitmask_b  = 16'($urandom);
        weights_b  = rand_weights();
      end
    end
    if (!fin) check("done_timeout", {31'd0, done}, 32'd1);

    fifo_full  = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_done", {31'd0, load_ready}, 32'd1);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("and_result_idle", {16'd0, and_result}, {16'd0, ab});
    check("count_idle", {27'd0, match_count}, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, load_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, valid_match}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_and"}, {16'd0, and_result}, 32'd0);
    check({tag, "_aout"}, {16'd0, bitmask_a_out}, 32'd0);
    check({tag, "_pos"}, {28'd0, matched_position}, 32'd0);
    check({tag, "_wt"}, {24'd0, matched_weight}, 32'd0);
    check({tag, "_cnt"}, {27'd0, match_count}, 32'd0);
  endtask

  task automatic reset_mid_scan();
    @(negedge clk);
    bitmask_a  = 16'hFFFF;
    bitmask_b  = 16'hFFFF;
    weights_b  = rand_weights();
    load_valid = 1'b1;
    fifo_full  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_pre_valid", {31'd0, valid_match}, 32'd1);
      check("rst_pre_pos", {28'd0, matched_position}, i);
    end
    // Assert reset between clock edges to observe the asynchronous clear.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("no_done_after_abort", {31'd0, done}, 32'd0);
      check("no_valid_after_abort", {31'd0, valid_match}, 32'd0);
    end
  endtask

  initial begin
    logic [127:0] w;
    logic [15:0]  ra, rb;

    rst        = 1'b1;
    load_valid = 1'b0;
    bitmask_a  = 16'h0000;
    bitmask_b  = 16'h0000;
    weights_b  = 128'd0;
    fifo_full  = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ordinary load.
    w = rand_weights();
    w[7:0]  = 8'h2C;
    w[15:8] = 8'h5A;
    run_pair(16'h002C, 16'h0024, w, 0, 0, 1'b0, 1'b0);

    // Empty intersection.
    run_pair(16'h00F0, 16'h000F, rand_weights(), 0, 0, 1'b0, 1'b0);

    // Backpressure for 3 cycles after the first emission.
    run_pair(16'h0007, 16'h0007, rand_weights(), 1, 3, 1'b0, 1'b0);

    // MSB boundary.
    w = rand_weights();
    w[7:0]  = 8'h11;
    w[15:8] = 8'hEE;
    run_pair(16'h8001, 16'h8001, w, 0, 0, 1'b0, 1'b0);

    // Reset mid-SCAN, then a fresh full-mask pair restarts at position 0.
    reset_mid_scan();
    run_pair(16'hFFFF, 16'hFFFF, rand_weights(), 0, 0, 1'b0, 1'b0);

    // Busy load attempts during SCAN.
    run_pair(16'h5A3C, 16'h7E18, rand_weights(), 0, 0, 1'b0, 1'b1);

    // Randomized pairs with random stalls and busy loads.
    for (int t = 0; t < 25; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_pair(ra, rb, rand_weights(), 0, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_match_dispatcher
